// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master (sequencer / bench) and the register responder.
interface axi_lite_slave_regs_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank responder: independent AW/W capture, byte strobes,
// OKAY/SLVERR responses, fully registered outputs.
module axi_lite_slave_regs #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_LSB = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_lite_slave_regs_if.slave  s_axi
);
  localparam int          IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] LIMIT  = 32'(NUM_REGS * 4);
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic             aw_hs, w_hs, ar_hs, commit, wr_in_range, rd_in_range;
  logic [31:0]      wr_addr, wr_data;
  logic [3:0]       wr_strb;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  always_comb begin
    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    aw_hs = s_axi.S_AXI_AWVALID & awready_q;
    w_hs  = s_axi.S_AXI_WVALID  & wready_q;
    ar_hs = s_axi.S_AXI_ARVALID & arready_q;

    // A handshake this cycle takes precedence; otherwise use the held copy.
    wr_addr = aw_hs ? s_axi.S_AXI_AWADDR : awaddr_q;
    wr_data = w_hs  ? s_axi.S_AXI_WDATA  : wdata_q;
    wr_strb = w_hs  ? s_axi.S_AXI_WSTRB  : wstrb_q;
    wr_idx  = wr_addr[ADDR_LSB +: IDX_W];
    wr_in_range = wr_addr < LIMIT;
    rd_idx  = s_axi.S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    rd_in_range = s_axi.S_AXI_ARADDR < LIMIT;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi.S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.S_AXI_WDATA;
      wstrb_d  = s_axi.S_AXI_WSTRB;
    end

    if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;

    commit = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? OKAY : SLVERR;
      if (wr_in_range) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end

    if (rvalid_q && s_axi.S_AXI_RREADY) rvalid_d = 1'b0;

    // Reads sample regs_q, so a same-edge write commit is not visible yet.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? regs_q[rd_idx] : 32'h0;
      rresp_d  = rd_in_range ? OKAY : SLVERR;
    end

    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d  & ~bvalid_d;
    arready_d = ~rvalid_d;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= 32'h0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: stimulus pushes expected responses,
// a negedge monitor pops and compares on every B/R handshake.
module tb_axi_lite_slave_regs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  axi_lite_slave_regs_if axi();

  axi_lite_slave_regs #(.NUM_REGS(4), .ADDR_LSB(2)) dut (
    .ACLK(clk), .ARESETn(rst_n), .s_axi(axi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 32'(axi.S_AXI_BVALID), 32'h0);
        else chk("bresp", 32'(axi.S_AXI_BRESP), 32'(bq.pop_front()));
      end
      if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 32'(axi.S_AXI_RVALID), 32'h0);
        else begin
          logic [33:0] e;
          e = rq.pop_front();
          chk("rdata", axi.S_AXI_RDATA, e[31:0]);
          chk("rresp", 32'(axi.S_AXI_RRESP), 32'(e[33:32]));
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] r);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    bq.push_back(r);
    axi.S_AXI_AWADDR = a; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = d; axi.S_AXI_WSTRB = s; axi.S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      aw_hs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_hs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; axi.S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  axi.S_AXI_WVALID = 1'b0; end
      n++;
    end
    if (!(aw_done && w_done)) chk("write_timeout", 32'(n), 32'h0);
    else chk("bvalid_after_commit", 32'(axi.S_AXI_BVALID), 32'h1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    bit hs = 0;
    int n = 0;
    rq.push_back({r, d});
    axi.S_AXI_ARADDR = a; axi.S_AXI_ARVALID = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
      @(posedge clk); #1;
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    if (!hs) chk("read_timeout", 32'(n), 32'h0);
    else chk("rvalid_after_ar", 32'(axi.S_AXI_RVALID), 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
      @(posedge clk); n++;
    end
    if (bq.size() != 0 || rq.size() != 0) chk("drain_timeout", 32'(bq.size() + rq.size()), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b1;

    // Reset state and ready release timing
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(axi.S_AXI_AWREADY), 32'h0);
    chk("rst_arready", 32'(axi.S_AXI_ARREADY), 32'h0);
    chk("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'h0);
    chk("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("awready_before_edge", 32'(axi.S_AXI_AWREADY), 32'h0);
    @(posedge clk); #1;
    chk("awready_after_rst", 32'(axi.S_AXI_AWREADY), 32'h1);
    chk("wready_after_rst", 32'(axi.S_AXI_WREADY), 32'h1);
    chk("arready_after_rst", 32'(axi.S_AXI_ARREADY), 32'h1);

    // In-flight write discarded by an asynchronous mid-cycle reset
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_AWADDR = 32'h0; axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA = 32'hFFFF_FFFF; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    chk("bvalid_pre_reset", 32'(axi.S_AXI_BVALID), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("bvalid_async_reset", 32'(axi.S_AXI_BVALID), 32'h0);
    chk("awready_async_reset", 32'(axi.S_AXI_AWREADY), 32'h0);
    @(negedge clk); rst_n = 1'b1; axi.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    do_read(32'h0, 32'h0, 2'b00);
    drain();

    // Basic write and read-back, AW/W together
    do_write(32'h4, 32'h1234_5678, 4'hF, 2'b00);
    chk("bresp_basic_live", 32'(axi.S_AXI_BRESP), 32'h0);
    @(posedge clk); #1;
    chk("bvalid_cleared", 32'(axi.S_AXI_BVALID), 32'h0);
    chk("awready_back", 32'(axi.S_AXI_AWREADY), 32'h1);
    do_read(32'h4, 32'h1234_5678, 2'b00);
    drain();

    // W leads AW by three cycles with partial strobes
    do_write(32'h8, 32'h1111_1111, 4'hF, 2'b00);
    drain();
    bq.push_back(2'b00);
    axi.S_AXI_WDATA = 32'hAABB_CCDD; axi.S_AXI_WSTRB = 4'b0101; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk); chk("wready_skew_start", 32'(axi.S_AXI_WREADY), 32'h1);
    @(posedge clk); #1;
    axi.S_AXI_WVALID = 1'b0;
    repeat (2) begin
      chk("wready_waiting", 32'(axi.S_AXI_WREADY), 32'h0);
      chk("bvalid_waiting", 32'(axi.S_AXI_BVALID), 32'h0);
      @(posedge clk); #1;
    end
    axi.S_AXI_AWADDR = 32'h8; axi.S_AXI_AWVALID = 1'b1;
    chk("wready_waiting", 32'(axi.S_AXI_WREADY), 32'h0);
    @(negedge clk); chk("awready_skew", 32'(axi.S_AXI_AWREADY), 32'h1);
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0;
    chk("bvalid_skew", 32'(axi.S_AXI_BVALID), 32'h1);
    drain();
    do_read(32'h8, 32'h11BB_11DD, 2'b00);
    drain();

    // Out-of-range write and read
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 2'b10);
    drain();
    do_read(32'h10, 32'h0, 2'b10);
    do_read(32'h0, 32'h0, 2'b00);
    do_read(32'h4, 32'h1234_5678, 2'b00);
    do_read(32'h8, 32'h11BB_11DD, 2'b00);
    do_read(32'hC, 32'h0, 2'b00);
    drain();

    // Zero strobes: OKAY, register unchanged
    do_write(32'h4, 32'hFFFF_FFFF, 4'h0, 2'b00);
    drain();
    do_read(32'h7, 32'h1234_5678, 2'b00);
    drain();

    // Backpressure on both channels
    do_write(32'hC, 32'h5, 4'hF, 2'b00);
    drain();
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
    fork
      do_write(32'h0, 32'hCAFE_0001, 4'hF, 2'b00);
      do_read(32'h4, 32'h1234_5678, 2'b00);
    join
    repeat (5) begin
      chk("bp_bvalid", 32'(axi.S_AXI_BVALID), 32'h1);
      chk("bp_bresp", 32'(axi.S_AXI_BRESP), 32'h0);
      chk("bp_rvalid", 32'(axi.S_AXI_RVALID), 32'h1);
      chk("bp_rdata", axi.S_AXI_RDATA, 32'h1234_5678);
      chk("bp_readies", {29'h0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'h0);
      @(posedge clk); #1;
    end
    axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    chk("bp_bvalid_released", 32'(axi.S_AXI_BVALID), 32'h0);
    chk("bp_rvalid_released", 32'(axi.S_AXI_RVALID), 32'h0);
    drain();
    do_read(32'h0, 32'hCAFE_0001, 2'b00);
    drain();

    // Same-edge read and write commit to 0xC: read sees the old value
    fork
      do_write(32'hC, 32'h9, 4'hF, 2'b00);
      do_read(32'hC, 32'h5, 2'b00);
    join
    drain();
    do_read(32'hC, 32'h9, 2'b00);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
